sar_conv_sequencer: RTL

- Successive-approximation sequencer that drives the 12-bit trial code into the capacitor-array row/column decoder.
- Controls the sample phase and comparator strobe, resolves one bit per two clocks (MSB first) and returns the converted word with a one-cycle valid pulse.
- Sits between the ADC top-level control (start/result) and the analog core (sample switch, comparator, array decoder).

---
 rtl/sar_conv_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sar_conv_sequencer.sv
// Successive-approximation conversion sequencer.
// Drives the sample switch, the comparator strobe and the trial code into the
// capacitor-array decoder, resolves one bit per two clocks MSB first, and
// returns the converted word with a one-cycle valid pulse.
module sar_conv_sequencer #(
    parameter int unsigned NBITS         = 12,
    parameter int unsigned SAMPLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             comp_in,
    output logic             sample,
    output logic             comp_strobe,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] result,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned KW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(NBITS - 1);
    localparam logic [3:0] CNT_LAST = 4'(SAMPLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_TRIAL,
        ST_DECIDE,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [KW-1:0]    r_k;
    logic [NBITS-1:0] r_work;
    logic             r_sample;
    logic             r_strobe;
    logic [NBITS-1:0] r_dac;
    logic [NBITS-1:0] r_result;
    logic             r_valid;
    logic             r_busy;

    logic [NBITS-1:0] w_bit;
    logic [NBITS-1:0] w_work_next;

    // One-hot mask of the bit under trial and the working word after this decision.
    assign w_bit       = NBITS'(1) << r_k;
    assign w_work_next = comp_in ? (r_work | w_bit) : r_work;

    // Conversion state machine; every output is updated alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_k      <= K_TOP;
            r_work   <= '0;
            r_sample <= 1'b0;
            r_strobe <= 1'b0;
            r_dac    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                // DONE shares the start check with IDLE so back-to-back
                // requests skip the idle cycle entirely.
                ST_IDLE, ST_DONE: begin
                    r_valid <= 1'b0;
                    r_dac   <= '0;
                    if (start) begin
                        r_state  <= ST_SAMPLE;
                        r_sample <= 1'b1;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_work   <= '0;
                        r_k      <= K_TOP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SAMPLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state  <= ST_TRIAL;
                        r_sample <= 1'b0;
                        r_strobe <= 1'b1;
                        r_dac    <= r_work | w_bit;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_TRIAL: begin
                    r_state  <= ST_DECIDE;
                    r_strobe <= 1'b0;
                end
                ST_DECIDE: begin
                    r_work <= w_work_next;
                    if (r_k != '0) begin
                        r_k      <= r_k - KW'(1);
                        r_state  <= ST_TRIAL;
                        r_strobe <= 1'b1;
                        r_dac    <= w_work_next | (w_bit >> 1);
                    end else begin
                        r_state  <= ST_DONE;
                        r_result <= w_work_next;
                        r_dac    <= w_work_next;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sample      = r_sample;
    assign comp_strobe = r_strobe;
    assign dac_code    = r_dac;
    assign result      = r_result;
    assign valid       = r_valid;
    assign busy        = r_busy;

endmodule
